// File: rtl/z80_bus_arbiter_pkg.sv
// Shared encodings and helpers for the Z80 bus arbiter slice.
package z80_bus_arbiter_pkg;

   localparam int NUM_REQ = 2;
   localparam int HOLD_W  = 8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_GRANT   = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   typedef logic [NUM_REQ-1:0] req_vec_t;

   // With both eligible the last owner yields; otherwise the lone eligible one wins.
   function automatic logic pick_winner(req_vec_t elig, logic last);
      return (elig[0] && elig[1]) ? ~last : elig[1];
   endfunction

endpackage

// File: rtl/z80_bus_arbiter_bus_sync.sv
// N-stage synchroniser for the asynchronous BUSAK line; idles high (deasserted).
module bus_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_pipe;

   always_ff @(posedge clk) begin
      if (reset) sync_pipe <= '1;
      else       sync_pipe <= {sync_pipe[STAGES-2:0], d};
   end

   assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/z80_bus_arbiter.sv
// Round-robin sharing of the Z80 bus between two requesters via BUSRQ/BUSAK,
// with a per-tenure hold watchdog, lockout and sticky timeout flags.
module z80_bus_arbiter
   import z80_bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD    = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               busrq_n,
   input  logic               busak_n,
   output logic               owner,
   output logic               busy,
   output logic [NUM_REQ-1:0] err_to,
   input  logic [NUM_REQ-1:0] err_clr
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic               ak_s;
   logic [1:0]         state, state_nx;
   logic [NUM_REQ-1:0] gnt_nx, lockout, lockout_nx, err_nx, to_set, elig;
   logic               busrq_nx, owner_nx;
   logic [HOLD_W-1:0]  hold_cnt, hold_nx;

   bus_sync #(.STAGES(SYNC_STAGES)) u_ak_sync (
      .clk   (clk),
      .reset (reset),
      .d     (busak_n),
      .q     (ak_s)
   );

   assign elig = req & ~lockout;
   assign busy = (state != ST_IDLE);

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      busrq_nx = busrq_n;
      owner_nx = owner;
      hold_nx  = hold_cnt;
      to_set   = '0;
      case (state)
         ST_IDLE: begin
            if (|elig) begin
               owner_nx = pick_winner(elig, owner);
               busrq_nx = 1'b0;
               state_nx = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!ak_s) begin
               // A request withdrawn before BUSAK never sees a grant pulse.
               if (req[owner]) begin
                  gnt_nx        = '0;
                  gnt_nx[owner] = 1'b1;
                  hold_nx       = '0;
                  state_nx      = ST_GRANT;
               end else begin
                  busrq_nx = 1'b1;
                  state_nx = ST_RELEASE;
               end
            end
         end
         ST_GRANT: begin
            if (!req[owner]) begin
               gnt_nx   = '0;
               busrq_nx = 1'b1;
               state_nx = ST_RELEASE;
            end else if (hold_cnt == HOLD_LAST) begin
               gnt_nx        = '0;
               busrq_nx      = 1'b1;
               to_set[owner] = 1'b1;
               state_nx      = ST_RELEASE;
            end else begin
               hold_nx = hold_cnt + 1'b1;
            end
         end
         ST_RELEASE: begin
            gnt_nx   = '0;
            busrq_nx = 1'b1;
            if (ak_s) state_nx = ST_IDLE;
         end
         default: begin
            gnt_nx   = '0;
            busrq_nx = 1'b1;
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Lockout persists until the requester drops req; a timeout set beats a clear.
   assign lockout_nx = (lockout | to_set) & req;
   assign err_nx     = (err_to & ~err_clr) | to_set;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         busrq_n  <= 1'b1;
         owner    <= 1'b1;
         err_to   <= '0;
         lockout  <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         gnt      <= gnt_nx;
         busrq_n  <= busrq_nx;
         owner    <= owner_nx;
         err_to   <= err_nx;
         lockout  <= lockout_nx;
         hold_cnt <= hold_nx;
      end
   end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter with a simple Z80 model acknowledging
// BUSRQ three cycles late.
module tb_z80_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       busak_n = 1'b1;
   logic [1:0] req = 2'b00;
   logic [1:0] err_clr = 2'b00;
   logic [1:0] gnt, err_to;
   logic       busrq_n, owner, busy;

   int n_vec = 0, n_miss = 0, n_two = 0, n_rqhi = 0;
   logic [3:0] dly = 4'hf;

   always #5 clk = ~clk;

   z80_bus_arbiter #(.MAX_HOLD(16), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .busrq_n (busrq_n),
      .busak_n (busak_n),
      .owner   (owner),
      .busy    (busy),
      .err_to  (err_to),
      .err_clr (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock; CPU model echoes busrq_n onto busak_n 3 cycles later.
   task automatic step();
      @(posedge clk);
      #1;
      dly     = {dly[2:0], busrq_n};
      busak_n = dly[3];
      if (gnt == 2'b11) n_two++;
      if (gnt != 2'b00 && busrq_n) n_rqhi++;
   endtask

   task automatic wait_gnt(input string tag, output int cyc);
      cyc = 0;
      while (gnt == 2'b00 && cyc < 60) begin
         step();
         cyc++;
      end
      chk({tag, "_gnt_seen"}, {31'd0, gnt != 2'b00}, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int c;
      c = 0;
      while (busy && c < 60) begin
         step();
         c++;
      end
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int c, seen_hi, bad, gseen;
      int exp_own [3] = '{0, 1, 0};

      repeat (3) step();
      reset = 1'b0;
      chk("rst_gnt", gnt, 0);
      chk("rst_busrq", busrq_n, 1);
      chk("rst_owner", owner, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_to, 0);

      // single request
      req = 2'b01;
      step();
      chk("single_busrq_lat", busrq_n, 0);
      chk("single_owner", owner, 0);
      c = 0;
      while (busak_n && c < 20) begin step(); c++; end
      c = 0;
      while (gnt == 2'b00 && c < 20) begin step(); c++; end
      chk("single_ak_to_gnt", c, 3);
      chk("single_gnt", gnt, 2'b01);
      repeat (4) step();
      chk("single_gnt_hold", gnt, 2'b01);
      req = 2'b00;
      step();
      chk("single_gnt_drop", gnt, 0);
      chk("single_busrq_rise", busrq_n, 1);
      chk("single_busy_rel", busy, 1);
      wait_idle("single");

      // withdrawal before BUSAK
      req = 2'b01;
      step();
      chk("wd_busrq", busrq_n, 0);
      req = 2'b00;
      gseen = 0;
      c = 0;
      while (busy && c < 60) begin
         step();
         c++;
         if (gnt != 2'b00) gseen = 1;
      end
      chk("wd_no_gnt", gseen, 0);
      chk("wd_busrq_back", busrq_n, 1);
      chk("wd_idle", busy, 0);

      // round-robin after a fresh reset
      reset = 1'b1;
      step();
      reset = 1'b0;
      req = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wait_gnt("rr", c);
         chk("rr_owner", owner, exp_own[k]);
         chk("rr_gnt", gnt, 2'b01 << exp_own[k]);
         repeat (9) step();
         chk("rr_gnt_held", gnt, 2'b01 << exp_own[k]);
         req[exp_own[k]] = 1'b0;
         step();
         chk("rr_gnt_drop", gnt, 0);
         chk("rr_busrq_rise", busrq_n, 1);
         if (k < 2) begin
            req = 2'b11;
            seen_hi = 0;
            bad = 0;
            c = 0;
            while (busrq_n && c < 40) begin
               step();
               c++;
               if (busak_n) seen_hi = 1;
               if (!busrq_n && seen_hi == 0) bad = 1;
            end
            chk("rr_gap", bad, 0);
         end else begin
            req = 2'b00;
            wait_idle("rr");
         end
      end

      // timeout on requester 1
      req = 2'b10;
      wait_gnt("to", c);
      chk("to_gnt", gnt, 2'b10);
      c = 0;
      while (gnt != 2'b00 && c < 100) begin step(); c++; end
      chk("to_len", c, 16);
      chk("to_err", err_to, 2'b10);
      bad = 0;
      repeat (40) begin
         step();
         if (gnt != 2'b00 || !busrq_n) bad++;
      end
      chk("to_lockout", bad, 0);
      chk("to_idle", busy, 0);
      req = 2'b00;
      step();
      req = 2'b10;
      wait_gnt("to_regrant", c);
      chk("to_regrant_gnt", gnt, 2'b10);
      req = 2'b00;
      wait_idle("to_regrant");
      chk("to_sticky", err_to, 2'b10);

      // reset mid-GRANT
      req = 2'b01;
      wait_gnt("rstg", c);
      repeat (3) step();
      reset = 1'b1;
      step();
      chk("rstg_gnt", gnt, 0);
      chk("rstg_busrq", busrq_n, 1);
      chk("rstg_err", err_to, 0);
      chk("rstg_owner", owner, 1);
      reset = 1'b0;
      req = 2'b00;
      repeat (8) step();

      // err_clr behaviour
      req = 2'b01;
      wait_gnt("ec", c);
      c = 0;
      while (gnt != 2'b00 && c < 100) begin step(); c++; end
      chk("ec_len", c, 16);
      chk("ec_set", err_to, 2'b01);
      req = 2'b00;
      step();
      err_clr = 2'b01;
      step();
      err_clr = 2'b00;
      chk("ec_clear", err_to, 2'b00);
      wait_idle("ec");
      req = 2'b01;
      wait_gnt("ec2", c);
      repeat (15) step();
      chk("ec2_gnt_last", gnt, 2'b01);
      err_clr = 2'b01;
      step();
      err_clr = 2'b00;
      chk("ec2_gnt_drop", gnt, 0);
      chk("ec2_set_wins", err_to, 2'b01);
      req = 2'b00;
      wait_idle("ec2");

      chk("one_hot", n_two, 0);
      chk("gnt_vs_busrq", n_rqhi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/z80_bus_arbiter.md
Name: z80_bus_arbiter

Overview:
- Shares the Z80 system bus (memory behind the romen/ramen/bank decode, plus the I/O space) between two on-board DMA-style requesters.
- Converts their requests into the Z80 BUSRQ/BUSAK handshake and issues one exclusive grant at a time.
- Arbitration is round-robin; a hold-time watchdog stops a stuck requester from starving the CPU.
- Sits beside the memory-map/clock logic in the same CPLD and is clocked from the undivided board clock.

Parameters:
- MAX_HOLD, 255, maximum GRANT cycles per tenure before forced release; legal range 1..255.
- SYNC_STAGES, 2, flip-flop stages on busak_n; legal range 2..3.

Ports:
- clk  input  1  board clock (undivided, same clock as the CPU clock generator).
- reset  input  1  synchronous, active-high reset.
- req  input  2  per-requester bus request, level; held high for the whole tenure.
- gnt  output  2  per-requester grant, one-hot or zero.
- busrq_n  output  1  to Z80 BUSRQ, active low.
- busak_n  input  1  from Z80 BUSAK, active low, asynchronous to clk.
- owner  output  1  index of the current or last granted requester.
- busy  output  1  high in any state other than IDLE.
- err_to  output  2  sticky per-requester timeout flags.
- err_clr  input  2  write-one-to-clear for err_to.

Behaviour:
- Reset values: state=IDLE, gnt=0, busrq_n=1, owner=1 (so requester 0 wins first), busy=0, err_to=0, lockout=0, hold_cnt=0, sync chain=1.
- busak_n passes through SYNC_STAGES flops to produce ak_s. The FSM uses only ak_s.
- Eligible requester: req[i]=1 and lockout[i]=0.
- IDLE
  - If any requester is eligible, pick a winner. With both eligible, the winner is ~owner. Otherwise it is the single eligible one.
  - Load owner=winner, drive busrq_n=0 on the next cycle, go to REQ.
- REQ
  - busrq_n=0; wait for ak_s=0. There is no timeout here: the Z80 always acknowledges at the end of its machine cycle.
  - On ak_s=0: if req[owner]=1, go to GRANT. Otherwise (request withdrawn) go to RELEASE without pulsing gnt.
  - A req change by the non-owner is ignored.
- GRANT
  - gnt[owner]=1, busrq_n=0; hold_cnt increments each cycle starting from 0.
  - If req[owner]=0: gnt drops in the same registered update, go to RELEASE.
  - Else if hold_cnt==MAX_HOLD-1: gnt=0, err_to[owner]=1, lockout[owner]=1, go to RELEASE.
  - Tenure therefore lasts at most MAX_HOLD cycles with gnt high.
- RELEASE
  - busrq_n=1, gnt=0; wait for ak_s=1, then go to IDLE.
  - No new grant is possible until BUSAK is seen deasserted.
- lockout[i] clears in any cycle where req[i]=0, so a timed-out requester must drop req before it is eligible again.
- err_clr[i]=1 clears err_to[i]. If a timeout set and err_clr coincide in the same cycle, the set wins.
- Latencies:
  - req rise to busrq_n fall: 1 cycle from IDLE.
  - BUSAK fall to gnt rise: SYNC_STAGES+1 cycles.
  - req fall to gnt fall: 1 cycle.
  - gnt fall to busrq_n rise: same cycle.
- gnt is never high while busrq_n=1 or while ak_s=1. At most one gnt bit is ever high.
- reset asserted mid-tenure: all outputs return to reset values on the next edge. busrq_n=1 releases the CPU; the requester sees gnt fall.

Decomposition:
- Shared package holds:
  - state encoding ST_IDLE=0, ST_REQ=1, ST_GRANT=2, ST_RELEASE=3;
  - HOLD_W=8;
  - NUM_REQ=2.
- One sub-module, bus_sync: an N-stage synchroniser for busak_n that resets to 1.
- Arbitration, counter and error logic stay in the top module.

Test Plan:
- Single request: req=01, busak_n falls 3 cycles after busrq_n falls.
  - Required: gnt=01 exactly SYNC_STAGES+1 cycles after the BUSAK fall.
  - Then req=00: gnt=00 and busrq_n=1 next cycle; busak_n rises; busy=0 after sync.
- Round-robin: both req held high through 3 tenures, each tenure releasing after 10 cycles (per-tenure req drop).
  - Required: owner sequence 0,1,0; never two gnt bits high; busrq_n high between tenures until BUSAK rises.
- Timeout with MAX_HOLD=16 and req[1] held high.
  - Required: gnt[1] high for exactly 16 cycles, err_to=10, no regrant to 1 while req[1] stays high.
  - req[1] low then high again: it is granted again.
- Withdrawal: req[0] pulses high 1 cycle, busak_n falls later.
  - Required: no gnt pulse, busrq_n returns to 1, FSM returns to IDLE after BUSAK rises.
- Reset mid-GRANT: reset pulsed for 1 cycle.
  - Required: gnt=00, busrq_n=1, err_to=00, owner=1 next edge.
- err_clr: set err_to[0] via timeout, then pulse err_clr=01.
  - Required: err_to=00 next cycle. With the pulse coincident with a second timeout, err_to[0] stays 1.
